// File: rtl/cpu_pkg.sv
// Shared encodings for the Simple RISC Machine controller: FSM states, opcode
// fields, ALU/shift codes and the decoded-instruction bundle.
package cpu_pkg;

  localparam logic [2:0] S_WAIT   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_GET_A  = 3'd2;
  localparam logic [2:0] S_GET_B  = 3'd3;
  localparam logic [2:0] S_ALU    = 3'd4;
  localparam logic [2:0] S_WB_REG = 3'd5;
  localparam logic [2:0] S_WB_IMM = 3'd6;

  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_ALU = 3'b101;

  // op sub-field values under OP_MOV
  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] MOV_IMM = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;

  typedef struct packed {
    logic is_movi;
    logic is_movr;
    logic is_add;
    logic is_cmp;
    logic is_and;
    logic is_mvn;
  } iclass_t;

  typedef struct packed {
    iclass_t     cls;
    logic [2:0]  rn;
    logic [2:0]  rd;
    logic [2:0]  rm;
    logic [1:0]  sh;
    logic [1:0]  op;
    logic [15:0] sximm8;
  } dec_t;

endpackage

// File: rtl/cpu_controller_instr_decoder.sv
// Combinational instruction decoder: splits IR into register fields, shift,
// op and sign-extended immediate, and flags the instruction class.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output dec_t        dec
);

  logic [2:0] opcode;
  logic [1:0] op;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];

  // Unlisted opcode/op pairs leave every class flag clear, i.e. NOP
  assign dec.cls.is_movi = (opcode == OP_MOV) && (op == MOV_IMM);
  assign dec.cls.is_movr = (opcode == OP_MOV) && (op == MOV_REG);
  assign dec.cls.is_add  = (opcode == OP_ALU) && (op == ALU_ADD);
  assign dec.cls.is_cmp  = (opcode == OP_ALU) && (op == ALU_SUB);
  assign dec.cls.is_and  = (opcode == OP_ALU) && (op == ALU_AND);
  assign dec.cls.is_mvn  = (opcode == OP_ALU) && (op == ALU_NOT);

  assign dec.rn     = ir[10:8];
  assign dec.rd     = ir[7:5];
  assign dec.sh     = ir[4:3];
  assign dec.rm     = ir[2:0];
  assign dec.op     = op;
  assign dec.sximm8 = {{8{ir[7]}}, ir[7:0]};

endmodule

// File: rtl/cpu_controller.sv
// Instruction register plus control FSM that sequences the datapath's read,
// operand-load, ALU and write-back controls for each instruction.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        vsel,
  output logic        loada,
  output logic        loadb,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic        loadc,
  output logic        loads,
  output logic [15:0] datapath_in
);

  logic [15:0] ir;
  logic [2:0]  state, state_nx;
  dec_t        dec;

  instr_decoder u_dec (
    .ir  (ir),
    .dec (dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      state <= state_nx;
      if (state == S_WAIT && load) ir <= in;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_WAIT:   if (s) state_nx = S_DECODE;
      S_DECODE: begin
        if (dec.cls.is_movi)                                         state_nx = S_WB_IMM;
        else if (dec.cls.is_movr || dec.cls.is_mvn)                  state_nx = S_GET_B;
        else if (dec.cls.is_add || dec.cls.is_cmp || dec.cls.is_and) state_nx = S_GET_A;
        else                                                         state_nx = S_WAIT;
      end
      S_GET_A:  state_nx = S_GET_B;
      S_GET_B:  state_nx = S_ALU;
      // CMP only updates status, so there is nothing to write back
      S_ALU:    state_nx = dec.cls.is_cmp ? S_WAIT : S_WB_REG;
      S_WB_REG: state_nx = S_WAIT;
      S_WB_IMM: state_nx = S_WAIT;
      default:  state_nx = S_WAIT;
    endcase
  end

  always_comb begin
    w        = 1'b0;
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    vsel     = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = SH_NONE;
    ALUop    = ALU_ADD;
    loadc    = 1'b0;
    loads    = 1'b0;
    case (state)
      S_WAIT:  w = 1'b1;
      S_GET_A: begin
        readnum = dec.rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = dec.rm;
        loadb   = 1'b1;
      end
      S_ALU: begin
        shift = dec.sh;
        ALUop = dec.op;
        asel  = dec.cls.is_movr;
        loads = dec.cls.is_cmp;
        loadc = ~dec.cls.is_cmp;
      end
      S_WB_REG: begin
        writenum = dec.rd;
        write    = 1'b1;
      end
      S_WB_IMM: begin
        writenum = dec.rn;
        vsel     = 1'b1;
        write    = 1'b1;
      end
      default: ;
    endcase
  end

  assign datapath_in = dec.sximm8;

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench: per-instruction expected output scripts built from the
// instruction class, compared cycle by cycle against the controller.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset, s, load;
  logic [15:0] in;
  logic        w, write, vsel, loada, loadb, asel, bsel, loadc, loads;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, ALUop;
  logic [15:0] datapath_in;

  cpu_controller dut (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
    .w(w), .readnum(readnum), .writenum(writenum), .write(write),
    .vsel(vsel), .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel),
    .shift(shift), .ALUop(ALUop), .loadc(loadc), .loads(loads),
    .datapath_in(datapath_in)
  );

  always #5 clk = ~clk;

  logic [34:0] obs;
  assign obs = {w, readnum, writenum, write, vsel, loada, loadb, asel, bsel,
                shift, ALUop, loadc, loads, datapath_in};

  int          nchk = 0;
  int          nfail = 0;
  logic [15:0] mir;
  logic [34:0] exq[$];
  bit          force_junk = 1'b0;

  task automatic chk(input string tag, input logic [34:0] got, input logic [34:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [34:0] mk(input logic wv, input logic [2:0] rnum, input logic [2:0] wnum,
                                     input logic wr, input logic vs, input logic la, input logic lb,
                                     input logic as, input logic [1:0] sh, input logic [1:0] alu,
                                     input logic lc, input logic ls, input logic [15:0] dp);
    return {wv, rnum, wnum, wr, vs, la, lb, as, 1'b0, sh, alu, lc, ls, dp};
  endfunction

  function automatic logic [15:0] sx8(input logic [15:0] ir);
    return {{8{ir[7]}}, ir[7:0]};
  endfunction

  // Expected busy-cycle outputs for one instruction, straight from its class
  task automatic build(input logic [15:0] ir);
    logic [15:0] dp;
    logic [34:0] vdec, vga, vgb, vwr, vwi;
    dp   = sx8(ir);
    vdec = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, dp);
    vga  = mk(0, ir[10:8], 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, dp);
    vgb  = mk(0, ir[2:0], 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, dp);
    vwr  = mk(0, 0, ir[7:5], 1, 0, 0, 0, 0, 0, 0, 0, 0, dp);
    vwi  = mk(0, 0, ir[10:8], 1, 1, 0, 0, 0, 0, 0, 0, 0, dp);
    exq.delete();
    exq.push_back(vdec);
    case ({ir[15:13], ir[12:11]})
      5'b110_10: exq.push_back(vwi);
      5'b110_00: begin
        exq.push_back(vgb);
        exq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, ir[4:3], ir[12:11], 1, 0, dp));
        exq.push_back(vwr);
      end
      5'b101_11: begin
        exq.push_back(vgb);
        exq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ir[4:3], ir[12:11], 1, 0, dp));
        exq.push_back(vwr);
      end
      5'b101_01: begin
        exq.push_back(vga);
        exq.push_back(vgb);
        exq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ir[4:3], ir[12:11], 0, 1, dp));
      end
      5'b101_00, 5'b101_10: begin
        exq.push_back(vga);
        exq.push_back(vgb);
        exq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, ir[4:3], ir[12:11], 1, 0, dp));
        exq.push_back(vwr);
      end
      default: ;
    endcase
  endtask

  // Called at a negedge while idle; leaves the bench at a negedge while idle
  task automatic issue(input string tag, input logic [15:0] instr, input bit ld, input int abort_at);
    int busy;
    in = instr; load = ld; s = 1'b1;
    if (ld) mir = instr;
    build(mir);
    busy = 0;
    for (int i = 0; i < exq.size(); i++) begin
      @(negedge clk);
      chk($sformatf("%s.c%0d", tag, i + 1), obs, exq[i]);
      if (!w) busy++;
      if (i == abort_at) begin
        reset = 1'b1; s = 1'b0; load = 1'b0;
        break;
      end
      if (force_junk) begin
        load = 1'b1; in = 16'hD0FF; s = 1'b1;
      end else begin
        s = 1'($urandom); load = 1'($urandom); in = 16'($urandom);
      end
    end
    if (abort_at >= 0) begin
      @(negedge clk);
      mir = '0;
      reset = 1'b0;
      chk({tag, ".rst"}, obs, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0));
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        chk($sformatf("%s.post%0d", tag, k), obs, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0));
      end
    end else begin
      @(negedge clk);
      chk({tag, ".busy"}, 35'(busy), 35'(exq.size()));
      chk({tag, ".idle"}, obs, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, sx8(mir)));
    end
    s = 1'b0; load = 1'b0;
  endtask

  initial begin
    logic [2:0] opc;
    reset = 1'b1; s = 1'b0; load = 1'b0; in = 16'h0; mir = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", obs, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0));
    reset = 1'b0;

    issue("movi",     16'hD007, 1'b1, -1);
    issue("movi_neg", 16'hD1FE, 1'b1, -1);
    issue("add",      16'hA148, 1'b1, -1);
    issue("cmp",      16'hA801, 1'b1, -1);
    issue("mvn",      16'hB860, 1'b1, -1);
    issue("movr",     16'hC041, 1'b1, -1);
    issue("reissue",  16'h0000, 1'b0, -1);
    force_junk = 1'b1;
    issue("busy_ld",  16'hA148, 1'b1, -1);
    force_junk = 1'b0;
    issue("ir_kept",  16'h1234, 1'b0, -1);
    issue("nop",      16'hE000, 1'b1, -1);
    issue("rst_getb", 16'hA148, 1'b1, 2);
    issue("post_rst", 16'hFFFF, 1'b0, -1);

    for (int n = 0; n < 60; n++) begin
      case ($urandom % 3)
        0:       opc = 3'b110;
        1:       opc = 3'b101;
        default: opc = 3'($urandom);
      endcase
      issue($sformatf("rnd%0d", n), {opc, 13'($urandom)}, ($urandom % 4) != 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule
